// File: rtl/adaptive_mode_controller.sv
// adaptive_mode_controller: LP (2-stage, clock-enabled) / HP (1-stage) decoder
// with drain-and-settle mode switching. Optional macro: MODE_SWITCH_STATS_EN.
module adaptive_mode_controller #(
  parameter int OPCODE_W      = 3,
  parameter int WINDOW        = 16,
  parameter int HI_THRESH     = 12,
  parameter int LO_THRESH     = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter bit RESET_MODE    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [OPCODE_W-1:0]          opcode,
  input  logic                         valid,
  output logic                         ready,
  input  logic                         auto_en,
  input  logic                         mode_req,
  output logic                         out_valid,
  output logic                         reg_write,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic                         alu_src,
  output logic                         branch,
  output logic                         jump,
  output logic [2:0]                   alu_op,
  output logic                         power_mode_active,
  output logic                         perf_mode_active,
  output logic                         switching,
  output logic [$clog2(WINDOW+1)-1:0]  activity_count,
  output logic [15:0]                  switch_count
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int YW = $clog2(WINDOW);
  localparam int SW = (SETTLE_CYCLES > 0) ?
                      $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [CW-1:0] WIN_C  = CW'(WINDOW);
  localparam logic [CW-1:0] HI_C   = CW'(HI_THRESH);
  localparam logic [CW-1:0] LO_C   = CW'(LO_THRESH);
  localparam logic [YW-1:0] LAST_C = YW'(WINDOW - 1);
  localparam logic [SW-1:0] SET_C  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] ONE_C  = SW'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode(
    input logic [OPCODE_W-1:0] op
  );
    ctrl_t      c;
    logic       hi;
    logic [2:0] lo;
    c  = '0;
    hi = |(op >> 3);
    lo = op[2:0];
    unique case (1'b1)
      (!hi && lo == 3'd0): begin
        c.reg_write = 1'b1;
        c.alu_op    = 3'b010;
      end
      (!hi && lo == 3'd1): begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
      end
      (!hi && lo == 3'd2): begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      (!hi && lo == 3'd3): begin
        c.branch = 1'b1;
        c.alu_op = 3'b001;
      end
      (!hi && lo == 3'd4): begin
        c.jump = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic [YW-1:0] cyc_q;
  logic [CW-1:0] acc_q;
  logic [CW-1:0] act_q;
  logic [CW-1:0] tally;
  logic          dec_q;

  logic          accept;
  logic          target;
  logic          empty;

  logic                s0_v;
  logic [OPCODE_W-1:0] s0_op;
  ctrl_t               s0_c;
  logic                s1_v;
  ctrl_t               s1_c;
  logic                o_v;
  ctrl_t               o_c;
  logic                lp_path;
  logic                o_in_v;
  ctrl_t               o_in_c;

  assign accept  = valid & ready;
  assign target  = auto_en ? dec_q : mode_req;
  assign empty   = ~(s0_v | s1_v | o_v);
  assign lp_path = ~mode_q;
  assign s0_c    = decode(s0_op);
  assign o_in_v  = lp_path ? s1_v : s0_v;
  assign o_in_c  = lp_path ? s1_c : s0_c;

  // Pipeline valid flags; cleared on reset so in-flight work is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
      o_v  <= 1'b0;
    end else begin
      s0_v <= accept;
      s1_v <= s0_v & lp_path;
      o_v  <= o_in_v;
    end
  end

  // Pipeline payload registers only load when their input is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_op <= '0;
      s1_c  <= '0;
      o_c   <= '0;
    end else begin
      if (accept)
        s0_op <= opcode;
      if (s0_v & lp_path)
        s1_c <= s0_c;
      if (o_in_v)
        o_c <= o_in_c;
    end
  end

  // Controls are forced low whenever no result is presented.
  always_comb begin
    out_valid = o_v;
    reg_write = o_v & o_c.reg_write;
    mem_read  = o_v & o_c.mem_read;
    mem_write = o_v & o_c.mem_write;
    alu_src   = o_v & o_c.alu_src;
    branch    = o_v & o_c.branch;
    jump      = o_v & o_c.jump;
    alu_op    = o_v ? o_c.alu_op : 3'b000;
  end

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= RESET_MODE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: SETTLE always lasts at least one cycle; the
  // new mode is the target sampled on the final SETTLE edge.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (target != mode_q)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) begin
          state_d = SETTLE;
          cnt_d   = SET_C;
        end
      end
      SETTLE: begin
        if (cnt_q <= ONE_C) begin
          state_d = RUN;
          mode_d  = target;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready             = (state_q == RUN);
    switching         = (state_q != RUN);
    power_mode_active = ~mode_q;
    perf_mode_active  = mode_q;
  end

  // Running tally including the accept on the current edge.
  always_comb begin
    tally = (acc_q == WIN_C) ? acc_q : acc_q + CW'(accept);
  end

  // Windowed activity monitor with hysteresis decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      acc_q <= '0;
      act_q <= '0;
      dec_q <= RESET_MODE;
    end else if (cyc_q == LAST_C) begin
      cyc_q <= '0;
      acc_q <= '0;
      act_q <= tally;
      if (tally >= HI_C)
        dec_q <= 1'b1;
      else if (tally <= LO_C)
        dec_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + YW'(1);
      acc_q <= tally;
    end
  end

  assign activity_count = act_q;

`ifdef MODE_SWITCH_STATS_EN
  logic        sw_done;
  logic [15:0] swc_q;

  assign sw_done = (state_q == SETTLE) &&
                   (state_d == RUN) &&
                   (mode_d != mode_q);

  // Saturating count of completed mode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      swc_q <= '0;
    else if (sw_done && swc_q != 16'hFFFF)
      swc_q <= swc_q + 16'd1;
  end

  assign switch_count = swc_q;
`else
  assign switch_count = 16'd0;
`endif

endmodule

// File: tb/tb_adaptive_mode_controller.sv
// tb_adaptive_mode_controller: random stimulus against a timestamp-based
// transaction model of decode, mode switching and activity windows.
`define CHK(nm) begin checks++; if (obs() !== expv) begin failures++; $display("FAIL %s edge=%0d got=%h expected=%h", nm, n, obs(), expv); end end

module tb_adaptive_mode_controller;

  localparam int W  = 16;
  localparam int HI = 12;
  localparam int LO = 4;
  localparam int S  = 2;
  localparam bit RM = 1'b0;
  localparam int CW = $clog2(W + 1);
  localparam int VW = 14 + CW + 16;
`ifdef MODE_SWITCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    opcode = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          auto_en = 1'b0;
  logic          mode_req = 1'b0;
  logic          out_valid;
  logic          reg_write, mem_read, mem_write;
  logic          alu_src, branch, jump;
  logic [2:0]    alu_op;
  logic          power_mode_active, perf_mode_active;
  logic          switching;
  logic [CW-1:0] activity_count;
  logic [15:0]   switch_count;

  always #5 clk = ~clk;

  adaptive_mode_controller #(
    .OPCODE_W(3), .WINDOW(W), .HI_THRESH(HI),
    .LO_THRESH(LO), .SETTLE_CYCLES(S), .RESET_MODE(RM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .valid(valid), .ready(ready), .auto_en(auto_en),
    .mode_req(mode_req), .out_valid(out_valid),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src),
    .branch(branch), .jump(jump), .alu_op(alu_op),
    .power_mode_active(power_mode_active),
    .perf_mode_active(perf_mode_active),
    .switching(switching),
    .activity_count(activity_count),
    .switch_count(switch_count)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;

  typedef struct {
    int         at;
    logic [8:0] ctrl;
  } ev_t;

  ev_t q[$];
  bit  m_mode, m_sw, m_dec;
  int  m_live, m_last_exit;
  int  m_cyc, m_acc, m_act, m_swc;
  logic [VW-1:0] expv;

  function automatic logic [8:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0:    return 9'b1_0_0_0_0_0_010;
      3'd1:    return 9'b1_1_0_1_0_0_000;
      3'd2:    return 9'b0_0_1_1_0_0_000;
      3'd3:    return 9'b0_0_0_0_1_0_001;
      3'd4:    return 9'b0_0_0_0_0_1_000;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [15:0] exp_swc(input int c);
    return STATS ? 16'(c) : 16'd0;
  endfunction

  function automatic logic [VW-1:0] obs();
    return {out_valid, reg_write, mem_read, mem_write,
            alu_src, branch, jump, alu_op, ready,
            power_mode_active, perf_mode_active, switching,
            activity_count, switch_count};
  endfunction

  task automatic model_reset();
    m_mode = RM; m_sw = 1'b0; m_dec = RM;
    m_live = 0; m_last_exit = -100;
    m_cyc = 0; m_acc = 0; m_act = 0; m_swc = 0;
    q.delete();
  endtask

  task automatic tick(input bit v, input logic [2:0] op,
                      input bit au, input bit rq);
    bit         tgt, acc;
    int         lat, e, tally;
    logic [9:0] eo;
    valid = v; opcode = op; auto_en = au; mode_req = rq;
    @(posedge clk);
    n++;
    tgt = au ? m_dec : rq;
    acc = v && !m_sw;
    if (acc) begin
      lat = m_mode ? 1 : 2;
      q.push_back('{n + lat, exp_ctrl(op)});
      m_last_exit = n + lat + 1;
    end
    if (!m_sw) begin
      if (tgt != m_mode) begin
        m_sw = 1'b1;
        e = (m_last_exit + 1 > n + 1) ? m_last_exit + 1 : n + 1;
        m_live = e + ((S > 1) ? S : 1);
      end
    end else if (n == m_live) begin
      if (tgt != m_mode) begin
        m_mode = tgt;
        if (m_swc < 65535) m_swc++;
      end
      m_sw = 1'b0;
    end
    tally = m_acc + int'(acc);
    if (tally > W) tally = W;
    if (m_cyc == W - 1) begin
      m_act = tally;
      m_acc = 0;
      if (tally >= HI) m_dec = 1'b1;
      else if (tally <= LO) m_dec = 1'b0;
    end else begin
      m_acc = tally;
    end
    m_cyc = (m_cyc + 1) % W;
    #1;
    eo = '0;
    if (q.size() > 0 && q[0].at == n) begin
      eo = {1'b1, q[0].ctrl};
      void'(q.pop_front());
    end
    expv = {eo, !m_sw, !m_mode, m_mode, m_sw,
            CW'(m_act), exp_swc(m_swc)};
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, reg_write, mem_read, mem_write, alu_src,
         branch, jump, alu_op} !== 10'b0 ||
        power_mode_active !== !RM || perf_mode_active !== RM ||
        switching !== 1'b0 || activity_count !== '0 ||
        switch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got=%h", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b expected=1", ready);
    end
  endtask

  task automatic test_lp_load();
    tick(1'b1, 3'b001, 1'b0, 1'b0);
    `CHK("lp_load_acc")
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 3'b000, 1'b0, 1'b0);
      `CHK("lp_load")
    end
  endtask

  task automatic wait_settled(input bit au, input bit rq,
                              input string nm);
    for (int i = 0; i < 40 && m_sw; i++) begin
      tick(1'b0, 3'b000, au, rq);
      `CHK(nm)
    end
    checks++;
    if (m_sw || ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout ready=%b expected=1", nm, ready);
    end
  endtask

  task automatic test_lp_to_hp();
    tick(1'b1, 3'($urandom_range(0, 4)), 1'b0, 1'b0);
    `CHK("burst0")
    tick(1'b1, 3'($urandom_range(0, 4)), 1'b0, 1'b0);
    `CHK("burst1")
    tick(1'b1, 3'($urandom_range(0, 4)), 1'b0, 1'b1);
    `CHK("burst2")
    wait_settled(1'b0, 1'b1, "lp_to_hp");
    tick(1'b1, 3'b100, 1'b0, 1'b1);
    `CHK("hp_jump_acc")
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 3'b000, 1'b0, 1'b1);
      `CHK("hp_jump")
    end
  endtask

  task automatic test_hp_back_to_back();
    logic [2:0] ops [5];
    int         pulses;
    ops = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd7};
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(i < 5, (i < 5) ? ops[i] : 3'd0, 1'b0, 1'b1);
      `CHK("hp_b2b")
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 5) begin
      failures++;
      $display("FAIL hp_b2b_pulses got=%0d expected=5", pulses);
    end
  endtask

  task automatic test_auto_mode();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 3'd0, 1'b1, 1'b1);
      `CHK("auto_idle")
    end
    for (int i = 0; i < 2 * W; i++) begin
      tick(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      `CHK("auto_full")
    end
    for (int i = 0; i < 3 * W; i++) begin
      tick((i % W) < 2, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
      `CHK("auto_sparse")
    end
    for (int i = 0; i < 3 * W; i++) begin
      tick((i % W) < 8, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
      `CHK("auto_mid")
    end
  endtask

  task automatic test_revert_in_drain();
    int saved;
    wait_settled(1'b0, 1'b0, "revert_pre");
    for (int i = 0; i < 30 && m_mode; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0);
      `CHK("revert_to_lp")
    end
    saved = m_swc;
    tick(1'b1, 3'b001, 1'b0, 1'b1);
    `CHK("revert_trig")
    tick(1'b0, 3'b000, 1'b0, 1'b1);
    `CHK("revert_hold")
    wait_settled(1'b0, 1'b0, "revert");
    checks++;
    if (switch_count !== exp_swc(saved) ||
        perf_mode_active !== 1'b0) begin
      failures++;
      $display("FAIL revert_stats count=%0d hp=%b expected=%0d/0",
               switch_count, perf_mode_active, exp_swc(saved));
    end
  endtask

  task automatic test_switch_count();
    int saved;
    bit rq;
    saved = m_swc;
    rq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rq = ~rq;
      tick(1'b0, 3'd0, 1'b0, rq);
      `CHK("swc_trig")
      wait_settled(1'b0, rq, "swc");
    end
    checks++;
    if (switch_count !== exp_swc(saved + 3)) begin
      failures++;
      $display("FAIL switch_count got=%0d expected=%0d",
               switch_count, exp_swc(saved + 3));
    end
  endtask

  task automatic test_reset_mid_drain();
    tick(1'b1, 3'($urandom_range(0, 4)), 1'b0, 1'b0);
    `CHK("rst_trig")
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    `CHK("rst_drain")
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, reg_write, mem_read, mem_write, alu_src,
         branch, jump, alu_op} !== 10'b0 || switching !== 1'b0 ||
        power_mode_active !== !RM || perf_mode_active !== RM ||
        switch_count !== 16'd0 || activity_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_drain got=%h", obs());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0);
      `CHK("post_reset")
    end
  endtask

  task automatic test_random();
    bit au, rq;
    au = 1'b0;
    rq = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) au = ~au;
      if ($urandom_range(0, 24) == 0) rq = ~rq;
      tick($urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), au, rq);
      `CHK("random")
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lp_load();
    test_lp_to_hp();
    test_hp_back_to_back();
    test_auto_mode();
    test_revert_in_drain();
    test_switch_count();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
